// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared definitions for the stack/memory access sequencer:
//            request op encodings, FSM state encoding and address width.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    // Request operations; encodings 5..7 are illegal and rejected with rsp_err.
    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_PUSH  = 3'd2,
        OP_POP   = 3'd3,
        OP_INC   = 3'd4
    } op_e;

    // Sequencer states. MODW is visited only by INC (write-back of mem+1).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MODW = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_INC);
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/stack_mem_ctrl_stack_pointer.sv
`default_nettype none
// ============================================================================
// Module   : stack_pointer
// Purpose  : Holds the stack pointer (next free slot, grows down) for the
//            stack_mem_ctrl sequencer and provides sp and sp+1.
// Ports    : clk, reset     - clock, async active-high reset (sp <= STACK_TOP)
//            push_i         - decrement sp this edge
//            pop_i          - increment sp this edge
//            hold_i         - suppress any update (bounds violation)
//            sp_o           - current stack pointer
//            sp_plus1_o     - sp + 1 (top-of-stack address for POP)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module stack_pointer
    import mem_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] sp_plus1_o
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (!hold_i) begin
            // Arithmetic is modulo 2^ADDR_W; wrap is intended when unchecked.
            if (push_i) begin
                sp_d = sp_q - 1'b1;
            end else if (pop_i) begin
                sp_d = sp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= STACK_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o       = sp_q;
    assign sp_plus1_o = sp_q + 1'b1;

endmodule : stack_pointer
`default_nettype wire

// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_ctrl
// Purpose  : Memory-access sequencer in front of a 256x8 data memory
//            (negedge write, combinational read). Executes one LOAD, STORE,
//            PUSH, POP or INC (read-modify-write) request at a time and
//            returns a one-cycle response pulse. Owns the stack pointer.
// Ports    : clk, reset              - clock, async active-high reset
//            req_valid/req_ready     - request handshake (ready in IDLE only)
//            req_op/addr/wdata       - request op, address, write data
//            rsp_valid/rdata/err     - one-cycle response pulse and payload
//            sp                      - current stack pointer
//            mem_address/data_in/
//            mem_write_enable        - drive to data memory
//            mem_data_out            - combinational read data from memory
// Config   : STACK_CHECK_EN - when defined, PUSH below STACK_LIMIT and POP
//            on an empty stack are rejected with rsp_err; otherwise sp wraps.
// Revision : 1.0 - initial release
// ============================================================================
module stack_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

`ifdef STACK_CHECK_EN
    localparam logic C_CHECK = 1'b1;
`else
    localparam logic C_CHECK = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] inc_q, inc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0] w_sp_plus1;
    logic              w_in_exec;
    logic              w_illegal;
    logic              w_push_err;
    logic              w_pop_err;
    logic              w_err;
    logic              w_sp_push;
    logic              w_sp_pop;

    // Error decode depends only on registered op and sp, so every memory
    // strobe derived from it is stable well before the memory's negedge.
    assign w_in_exec  = (state_q == ST_EXEC);
    assign w_illegal  = op_is_illegal(op_q);
    assign w_push_err = C_CHECK && (op_q == OP_PUSH) && (sp < STACK_LIMIT);
    assign w_pop_err  = C_CHECK && (op_q == OP_POP) && (sp == STACK_TOP);
    assign w_err      = w_illegal || w_push_err || w_pop_err;
    assign w_sp_push  = w_in_exec && (op_q == OP_PUSH);
    assign w_sp_pop   = w_in_exec && (op_q == OP_POP);

    stack_pointer #(
        .STACK_TOP (STACK_TOP)
    ) u_stack_pointer (
        .clk        (clk),
        .reset      (reset),
        .push_i     (w_sp_push),
        .pop_i      (w_sp_pop),
        .hold_i     (w_push_err || w_pop_err),
        .sp_o       (sp),
        .sp_plus1_o (w_sp_plus1)
    );

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        inc_d            = inc_q;
        rsp_valid_d      = 1'b0;
        rsp_rdata_d      = rsp_rdata_q;
        rsp_err_d        = rsp_err_q;
        req_ready        = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Default payload: zero data, flag any rejection.
                rsp_rdata_d = '0;
                rsp_err_d   = w_err;
                state_d     = ST_RESP;
                case (op_q)
                    OP_LOAD: begin
                        mem_address = addr_q;
                        rsp_rdata_d = mem_data_out;
                    end
                    OP_STORE: begin
                        mem_address      = addr_q;
                        mem_data_in      = wdata_q;
                        mem_write_enable = 1'b1;
                    end
                    OP_PUSH: begin
                        if (!w_push_err) begin
                            mem_address      = sp;
                            mem_data_in      = wdata_q;
                            mem_write_enable = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (!w_pop_err) begin
                            mem_address = w_sp_plus1;
                            rsp_rdata_d = mem_data_out;
                        end
                    end
                    OP_INC: begin
                        mem_address = addr_q;
                        inc_d       = mem_data_out + 1'b1;
                        state_d     = ST_MODW;
                    end
                    default: begin
                        // Illegal op: no memory access at all.
                    end
                endcase
            end

            ST_MODW: begin
                mem_address      = addr_q;
                mem_data_in      = inc_q;
                mem_write_enable = 1'b1;
                rsp_rdata_d      = inc_q;
                state_d          = ST_RESP;
            end

            ST_RESP: begin
                // The response pulse is registered here, so it appears in
                // the cycle after leaving RESP (back in IDLE).
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            inc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            inc_q       <= inc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : stack_mem_ctrl
`default_nettype wire

// File: tb/tb_stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_mem_ctrl
// Purpose  : Directed self-checking bench for stack_mem_ctrl paired with a
//            behavioural 256x8 data memory (negedge write, comb read).
//            Build with STACK_CHECK_EN defined to exercise the bounds checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] sp;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write_enable;
    logic [7:0] mem_data_out;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    stack_mem_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .sp               (sp),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    // Data memory model
    logic [7:0] mem [0:255];
    int         we_count = 0;

    always @(negedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
            we_count         <= we_count + 1;
        end
    end

    assign mem_data_out = mem[mem_address];

    // Results of the last request
    logic [7:0] r_data;
    logic       r_err;
    int         r_lat;
    logic       r_extra;

    // Issue one request from IDLE and collect the response.
    // r_lat = edges after the accept edge at which rsp_valid was seen, -1 on timeout.
    task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
        r_lat     = -1;
        r_data    = 8'hXX;
        r_err     = 1'bx;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                r_lat  = k;
                r_data = rsp_rdata;
                r_err  = rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        r_extra = rsp_valid;
    endtask

    task automatic hold_reset;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (sp !== 8'hFF || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_rsp: sp=%h valid=%b rdata=%h err=%b, want FF 0 00 0",
                     sp, rsp_valid, rsp_rdata, rsp_err);
        end
        chk_cnt++;
        if (mem_write_enable !== 1'b0 || mem_address !== 8'h00 || mem_data_in !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_mem: we=%b addr=%h din=%h, want 0 00 00",
                     mem_write_enable, mem_address, mem_data_in);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_load_store;
        do_req(3'd1, 8'h10, 8'h5A);
        chk_cnt++;
        if (r_lat !== 2 || r_err !== 1'b0 || r_data !== 8'h00 || r_extra !== 1'b0) begin
            err_cnt++;
            $display("FAIL store_rsp: lat=%0d err=%b rdata=%h extra=%b, want 2 0 00 0",
                     r_lat, r_err, r_data, r_extra);
        end
        chk_cnt++;
        if (mem[8'h10] !== 8'h5A) begin
            err_cnt++;
            $display("FAIL store_mem: mem[10]=%h, want 5A", mem[8'h10]);
        end
        do_req(3'd0, 8'h10, 8'h00);
        chk_cnt++;
        if (r_lat !== 2 || r_err !== 1'b0 || r_data !== 8'h5A) begin
            err_cnt++;
            $display("FAIL load_rsp: lat=%0d err=%b rdata=%h, want 2 0 5A", r_lat, r_err, r_data);
        end
    endtask

    task automatic test_stack;
        logic [7:0] exp_sp   [4] = '{8'hFE, 8'hFD, 8'hFE, 8'hFF};
        logic [2:0] ops      [4] = '{3'd2, 3'd2, 3'd3, 3'd3};
        logic [7:0] wd       [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
        logic [7:0] exp_data [4] = '{8'h00, 8'h00, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], 8'h00, wd[i]);
            chk_cnt++;
            if (r_lat !== 2 || r_err !== 1'b0 || r_data !== exp_data[i] || sp !== exp_sp[i]) begin
                err_cnt++;
                $display("FAIL stack_%0d: lat=%0d err=%b rdata=%h sp=%h, want 2 0 %h %h",
                         i, r_lat, r_err, r_data, sp, exp_data[i], exp_sp[i]);
            end
        end
        chk_cnt++;
        if (mem[8'hFF] !== 8'h11 || mem[8'hFE] !== 8'h22) begin
            err_cnt++;
            $display("FAIL stack_mem: mem[FF]=%h mem[FE]=%h, want 11 22", mem[8'hFF], mem[8'hFE]);
        end
    endtask

    task automatic test_inc;
        mem[8'h20] = 8'hFF;
        mem[8'h41] = 8'h41;
        do_req(3'd4, 8'h20, 8'h00);
        chk_cnt++;
        if (r_lat !== 3 || r_err !== 1'b0 || r_data !== 8'h00 || r_extra !== 1'b0) begin
            err_cnt++;
            $display("FAIL inc_wrap: lat=%0d err=%b rdata=%h extra=%b, want 3 0 00 0",
                     r_lat, r_err, r_data, r_extra);
        end
        do_req(3'd0, 8'h20, 8'h00);
        chk_cnt++;
        if (r_data !== 8'h00 || r_lat !== 2) begin
            err_cnt++;
            $display("FAIL inc_load: rdata=%h lat=%0d, want 00 2", r_data, r_lat);
        end
        do_req(3'd4, 8'h41, 8'h00);
        chk_cnt++;
        if (r_data !== 8'h42 || mem[8'h41] !== 8'h42) begin
            err_cnt++;
            $display("FAIL inc_plain: rdata=%h mem[41]=%h, want 42 42", r_data, mem[8'h41]);
        end
    endtask

    task automatic test_illegal;
        int         we_before;
        logic [7:0] sp_before;
        mem[8'h50] = 8'h33;
        we_before  = we_count;
        sp_before  = sp;
        do_req(3'd6, 8'h50, 8'h99);
        chk_cnt++;
        if (r_lat !== 2 || r_err !== 1'b1 || r_data !== 8'h00) begin
            err_cnt++;
            $display("FAIL illegal_rsp: lat=%0d err=%b rdata=%h, want 2 1 00", r_lat, r_err, r_data);
        end
        chk_cnt++;
        if (we_count !== we_before || mem[8'h50] !== 8'h33 || sp !== sp_before) begin
            err_cnt++;
            $display("FAIL illegal_side: writes=%0d mem[50]=%h sp=%h, want %0d 33 %h",
                     we_count - we_before, mem[8'h50], sp, 0, sp_before);
        end
    endtask

    task automatic test_stack_bounds;
        int we_before;
        hold_reset();
        do_req(3'd3, 8'h00, 8'h00);
`ifdef STACK_CHECK_EN
        chk_cnt++;
        if (r_err !== 1'b1 || r_data !== 8'h00 || sp !== 8'hFF) begin
            err_cnt++;
            $display("FAIL pop_empty: err=%b rdata=%h sp=%h, want 1 00 FF", r_err, r_data, sp);
        end
        for (int i = 0; i < 128; i++) begin
            do_req(3'd2, 8'h00, 8'(i));
        end
        chk_cnt++;
        if (sp !== 8'h7F || mem[8'h80] !== 8'h7F || r_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL push_fill: sp=%h mem[80]=%h err=%b, want 7F 7F 0", sp, mem[8'h80], r_err);
        end
        we_before = we_count;
        do_req(3'd2, 8'h00, 8'hAB);
        chk_cnt++;
        if (r_err !== 1'b1 || sp !== 8'h7F || we_count !== we_before) begin
            err_cnt++;
            $display("FAIL push_full: err=%b sp=%h writes=%0d, want 1 7F 0",
                     r_err, sp, we_count - we_before);
        end
`else
        we_before = we_count;
        chk_cnt++;
        if (r_err !== 1'b0 || sp !== 8'h00 || r_lat !== 2) begin
            err_cnt++;
            $display("FAIL pop_wrap: err=%b sp=%h lat=%0d, want 0 00 2", r_err, sp, r_lat);
        end
        do_req(3'd2, 8'h00, 8'hC3);
        chk_cnt++;
        if (r_err !== 1'b0 || sp !== 8'hFF || mem[8'h00] !== 8'hC3 || we_count !== we_before + 1) begin
            err_cnt++;
            $display("FAIL push_wrap: err=%b sp=%h mem[00]=%h, want 0 FF C3", r_err, sp, mem[8'h00]);
        end
`endif
    endtask

    task automatic test_reset_midop;
        hold_reset();
        mem[8'h30] = 8'h77;
        req_op     = 3'd1;
        req_addr   = 8'h30;
        req_wdata  = 8'hEE;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk_cnt++;
        if (mem_write_enable !== 1'b1 || mem_address !== 8'h30) begin
            err_cnt++;
            $display("FAIL midop_exec: we=%b addr=%h, want 1 30", mem_write_enable, mem_address);
        end
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (mem_write_enable !== 1'b0 || mem_address !== 8'h00) begin
            err_cnt++;
            $display("FAIL midop_we: we=%b addr=%h, want 0 00", mem_write_enable, mem_address);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (req_ready !== 1'b1 || sp !== 8'hFF || mem[8'h30] !== 8'h77 || rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL midop_after: ready=%b sp=%h mem[30]=%h valid=%b, want 1 FF 77 0",
                     req_ready, sp, mem[8'h30], rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end
        test_reset();
        test_load_store();
        test_stack();
        test_inc();
        test_illegal();
        test_stack_bounds();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule : tb_stack_mem_ctrl
`default_nettype wire
